// File: rtl/sobel_edge_core.sv
// Sobel gradient magnitude core: 3x3 windows in, four saturated 8-bit results packed per 32-bit
// write. Define SOBEL_THRESH_EN to binarise each result against `threshold`.
module sobel_edge_core #(
  parameter int unsigned NUM_PIX = 1024
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [31:0]          out_base_addr,
  input  logic                 win_valid,
  input  logic [2:0][2:0][7:0] window,
  output logic                 win_ready,
  input  logic [7:0]           threshold,
  output logic                 wr_en,
  output logic [31:0]          wr_addr,
  output logic [3:0][7:0]      wr_data,
  input  logic                 wr_ready,
  output logic                 busy,
  output logic                 edge_detect_done
);

  localparam int unsigned NumWords = NUM_PIX / 4;
  localparam int unsigned CntW     = $clog2(NUM_PIX + 1);
  localparam logic [CntW-1:0] LastWin  = CntW'(NUM_PIX - 1);
  localparam logic [CntW-1:0] LastWord = CntW'(NumWords - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e state_q, state_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;

  logic [CntW-1:0] win_cnt_q, win_cnt_d;
  logic [CntW-1:0] word_cnt_q, word_cnt_d;

  logic               s1_vld_q, s1_vld_d;
  logic signed [10:0] gx_q, gx_d;
  logic signed [10:0] gy_q, gy_d;
  logic               s2_vld_q, s2_vld_d;
  logic [7:0]         pix_q, pix_d;

  logic [1:0]      lane_q, lane_d;
  logic [2:0][7:0] pack_q, pack_d;
  logic            wr_en_q, wr_en_d;
  logic [31:0]     wr_addr_q, wr_addr_d;
  logic [3:0][7:0] wr_data_q, wr_data_d;

  logic stall, win_acc, wr_acc;

  assign stall     = wr_en_q && !wr_ready;
  assign win_ready = (state_q == StRun) && !stall;
  assign win_acc   = win_valid && win_ready;
  assign wr_acc    = wr_en_q && wr_ready;

  // S1 operands: each weighted column/row sum is at most 4*255 = 1020, fits 10 bits unsigned.
  logic [9:0] gx_pos, gx_neg, gy_pos, gy_neg;
  assign gx_pos = 10'(window[0][2]) + {1'b0, window[1][2], 1'b0} + 10'(window[2][2]);
  assign gx_neg = 10'(window[0][0]) + {1'b0, window[1][0], 1'b0} + 10'(window[2][0]);
  assign gy_pos = 10'(window[2][0]) + {1'b0, window[2][1], 1'b0} + 10'(window[2][2]);
  assign gy_neg = 10'(window[0][0]) + {1'b0, window[0][1], 1'b0} + 10'(window[0][2]);

  logic [10:0] abs_x, abs_y, mag;
  logic [7:0]  sat, s2_res;

  always_comb begin
    abs_x = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
    abs_y = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
    mag   = abs_x + abs_y;
    sat   = (mag > 11'd255) ? 8'hFF : mag[7:0];
`ifdef SOBEL_THRESH_EN
    s2_res = (sat >= threshold) ? 8'hFF : 8'h00;
`else
    s2_res = sat;
`endif
  end

`ifndef SOBEL_THRESH_EN
  logic unused_threshold;
  assign unused_threshold = ^threshold;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (win_acc && win_cnt_q == LastWin) state_d = StFlush;
      StFlush: if (wr_acc && word_cnt_q == LastWord) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  always_comb begin
    s1_vld_d   = s1_vld_q;
    gx_d       = gx_q;
    gy_d       = gy_q;
    s2_vld_d   = s2_vld_q;
    pix_d      = pix_q;
    lane_d     = lane_q;
    pack_d     = pack_q;
    wr_en_d    = wr_en_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    win_cnt_d  = win_cnt_q;
    word_cnt_d = word_cnt_q;

    if (state_q == StIdle && start) begin
      s1_vld_d   = 1'b0;
      s2_vld_d   = 1'b0;
      lane_d     = 2'd0;
      wr_en_d    = 1'b0;
      wr_addr_d  = out_base_addr;
      win_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (!stall) begin
      s1_vld_d = win_acc;
      if (win_acc) begin
        gx_d      = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
        gy_d      = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});
        win_cnt_d = win_cnt_q + 1'b1;
      end

      s2_vld_d = s1_vld_q;
      if (s1_vld_q) pix_d = s2_res;

      if (wr_acc) begin
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q + 32'd4;
        word_cnt_d = word_cnt_q + 1'b1;
      end

      // A word completing on the acceptance edge reloads the port without a bubble.
      if (s2_vld_q) begin
        if (lane_q == 2'd3) begin
          wr_data_d = {pix_q, pack_q};
          wr_en_d   = 1'b1;
        end else begin
          pack_d[lane_q] = pix_q;
        end
        lane_d = lane_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_vld_q   <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
      s2_vld_q   <= 1'b0;
      pix_q      <= '0;
      lane_q     <= '0;
      pack_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      win_cnt_q  <= '0;
      word_cnt_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      s2_vld_q   <= s2_vld_d;
      pix_q      <= pix_d;
      lane_q     <= lane_d;
      pack_q     <= pack_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      win_cnt_q  <= win_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign wr_en            = wr_en_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign busy             = busy_q;
  assign edge_detect_done = done_q;

endmodule
